pid_gen: RTL and testbench
==========================

# pid_gen

Parametrised next-generation PID heading controller for the tour robot drive train. It takes the heading error and forward-speed command and produces signed left and right wheel speeds. Gains are run-time ports and the integrator clamps instead of wrapping. A two-stage register pipeline carries an output-valid strobe, and the derivative term is compile-time optional. The block sits between the heading-error source and the motor PWM/drive logic.

## Interface
- ERR_W, 12, raw signed error width
- ERR_SAT_W, 10, saturated error width (signed)
- FRWRD_W, 10, unsigned forward command width
- SPD_W, 11, signed wheel-speed width (FRWRD_W+1)
- GAIN_W, 5, unsigned gain width for kp/kd
- INTEG_W, 18, signed integrator width
- I_SHIFT, 6, integrator arithmetic right shift
- D_DEPTH, 2, valid samples back for derivative (>=1)
- D_SAT_W, 8, saturated derivative-difference width
- SUM_W, 17, PID sum width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- moving  in  1  robot moving; low clears controller state
- err_vld  in  1  new error sample strobe
- error  in  ERR_W  signed heading error
- frwrd  in  FRWRD_W  unsigned forward speed
- kp  in  GAIN_W  proportional gain
- kd  in  GAIN_W  derivative gain
- lft_spd  out  SPD_W  signed left speed
- rght_spd  out  SPD_W  signed right speed
- out_vld  out  1  one-cycle pulse, speeds reflect newest sample

## Operation
- err_sat = error saturated to ERR_SAT_W signed (±511 default).
- P = err_sat * {0,kp}, signed, width ERR_SAT_W+GAIN_W+1.
- Integrator: integ_nxt = clamp_INTEG_W(integ + sext(err_sat)). Never wraps.
- I = integ_nxt >>> I_SHIFT.
- History: D_DEPTH-entry shift register of err_sat. It shifts only on accepted samples.
- D = clamp_D_SAT_W(err_sat − hist[D_DEPTH-1]) * {0,kd}.
- Stage 1 registers P, I, D, integ and history on edges where err_vld && moving. The terms use the current error and the pre-update history.
- Stage 2 updates every edge.
  - sum = sext_SUM_W(P+I+D); pid = sum >>> 3.
  - lft = sat_SPD_W({0,frwrd} + pid); rght = sat_SPD_W({0,frwrd} − pid).
  - If !moving, both are 0.
- Stage 2 uses the current frwrd and the stage-1 term registers.
- moving low on an edge clears integ, history and the term registers. This clear wins over a simultaneous err_vld.

## Timing
- Reset: every register is 0, including lft_spd, rght_spd, out_vld, integ and history.
- Latency:
  - err_vld sampled at edge k updates stage 1 at edge k.
  - lft_spd/rght_spd reflect that sample after edge k+1.
  - out_vld is high for the cycle following edge k+1.
- Back-to-back err_vld is allowed, at one sample per cycle. out_vld is then continuously high.
- out_vld is suppressed when moving was low at edge k.
- A frwrd change alone shows on the speeds after one edge, with no out_vld.
- rst mid-operation aborts in-flight samples. Outputs are 0 the next cycle.

## Configuration
- PID_DTERM_EN defined: history register and D term are present.
- PID_DTERM_EN undefined:
  - No history registers; D = 0.
  - The kd port remains but is ignored.
  - Latency is unchanged.

## Structure
- Package pid_pkg holds:
  - default width localparams
  - signed saturate/clamp function
  - a typedef struct for the stage-1 term bundle {P, I, D}
- Sub-module pid_err_hist: the parametrised D_DEPTH shift register with shift enable and synchronous clear. It is instantiated only under PID_DTERM_EN.

## Test plan
- Reset: rst=1 for 2 cycles, err_vld=1, error=0x100 → lft_spd=rght_spd=0, out_vld=0 throughout.
- P path: kp=2, kd=0, frwrd=0x100, moving=1, one err_vld pulse with error=0x100. Expected P=512, I=4, pid=64, giving lft=0x140 and rght=0x0C0, with out_vld one cycle after the stage-1 edge.
- Saturation: error=0x7FF (err_sat=511), kp=31, frwrd=0x100, one pulse. Expected sum=15848, giving lft=0x3FF and rght=0x400.
- Integrator clamp: kp=kd=0, error=511, 300 consecutive err_vld. Expected integ=131071 (clamped), giving lft=0x1FF and rght=0x001.
- Moving drop: after the clamp test, moving=0 with err_vld=1. Expected outputs 0 next edge and integ=0. Then moving=1 with error=0 gives lft=rght=0x100.
- Derivative: kp=0, kd=4, frwrd=0x100, pulses with error 0, 0, 100.
  - With PID_DTERM_EN: lft=0x132, rght=0x0CE.
  - Without PID_DTERM_EN: lft=rght=0x100.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared widths, stage-1 term bundle and the signed saturate helper for the pid_gen heading controller.
package pid_pkg;

  localparam int DEF_ERR_W     = 12;
  localparam int DEF_ERR_SAT_W = 10;
  localparam int DEF_FRWRD_W   = 10;
  localparam int DEF_SPD_W     = 11;
  localparam int DEF_GAIN_W    = 5;
  localparam int DEF_INTEG_W   = 18;
  localparam int DEF_I_SHIFT   = 6;
  localparam int DEF_D_DEPTH   = 2;
  localparam int DEF_D_SAT_W   = 8;
  localparam int DEF_SUM_W     = 17;

  // Each term is held at sum width so the stage-2 add needs no per-term extension.
  typedef struct packed {
    logic signed [DEF_SUM_W-1:0] p;
    logic signed [DEF_SUM_W-1:0] i;
    logic signed [DEF_SUM_W-1:0] d;
  } terms_t;

  // Clamp a 32-bit signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pid_err_hist.sv
// Saturated-error history: DEPTH-entry shift register, shifts on accepted samples, synchronous clear.
// One-cycle update; no flow control, oldest entry is always visible.
module pid_err_hist #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest
);

  logic signed [W-1:0] hist [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (shift) begin
      hist[0] <= din;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign oldest = hist[DEPTH-1];

endmodule

// File: rtl/pid_gen.sv
// PID heading controller: two-stage pipeline, speeds and out_vld follow an accepted sample by one edge;
// no backpressure, one sample per cycle. Derivative term present only when PID_DTERM_EN is defined.
module pid_gen
  import pid_pkg::*;
#(
  parameter int ERR_W     = DEF_ERR_W,
  parameter int ERR_SAT_W = DEF_ERR_SAT_W,
  parameter int FRWRD_W   = DEF_FRWRD_W,
  parameter int SPD_W     = DEF_SPD_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int INTEG_W   = DEF_INTEG_W,
  parameter int I_SHIFT   = DEF_I_SHIFT,
  parameter int D_DEPTH   = DEF_D_DEPTH,
  parameter int D_SAT_W   = DEF_D_SAT_W,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    moving,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] error,
  input  logic [FRWRD_W-1:0]      frwrd,
  input  logic [GAIN_W-1:0]       kp,
  input  logic [GAIN_W-1:0]       kd,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    out_vld
);

  logic                        accept;
  logic signed [ERR_SAT_W-1:0] err_sat;
  logic signed [INTEG_W-1:0]   integ;
  logic signed [INTEG_W-1:0]   integ_nxt;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SPD_W-1:0]     lft_nxt;
  logic signed [SPD_W-1:0]     rght_nxt;
  logic                        s1_vld;
  terms_t                      terms;
  terms_t                      terms_nxt;
  logic signed [31:0]          t_err, t_p, t_int, t_i, t_d, t_sum, t_pid, t_l, t_r;
  logic                        unused_bits;

  assign accept = err_vld && moving;

`ifdef PID_DTERM_EN
  logic signed [ERR_SAT_W-1:0] hist_old;

  pid_err_hist #(
    .W     (ERR_SAT_W),
    .DEPTH (D_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .clr    (!moving),
    .shift  (accept),
    .din    (err_sat),
    .oldest (hist_old)
  );
`else
  logic unused_kd;
  assign unused_kd = ^kd;
`endif

  always_comb begin
    t_err     = sat_s(32'(error), ERR_SAT_W);
    err_sat   = t_err[ERR_SAT_W-1:0];
    t_p       = 32'(err_sat) * $signed(32'(kp));
    t_int     = sat_s(32'(integ) + 32'(err_sat), INTEG_W);
    integ_nxt = t_int[INTEG_W-1:0];
    t_i       = 32'(integ_nxt) >>> I_SHIFT;
`ifdef PID_DTERM_EN
    // History is read before this sample shifts in, so the difference spans D_DEPTH samples.
    t_d       = sat_s(32'(err_sat) - 32'(hist_old), D_SAT_W) * $signed(32'(kd));
`else
    t_d       = '0;
`endif
    terms_nxt.p = t_p[SUM_W-1:0];
    terms_nxt.i = t_i[SUM_W-1:0];
    terms_nxt.d = t_d[SUM_W-1:0];

    t_sum    = 32'(terms.p) + 32'(terms.i) + 32'(terms.d);
    sum      = t_sum[SUM_W-1:0];
    t_pid    = 32'(sum) >>> 3;
    t_l      = sat_s($signed(32'(frwrd)) + t_pid, SPD_W);
    t_r      = sat_s($signed(32'(frwrd)) - t_pid, SPD_W);
    lft_nxt  = t_l[SPD_W-1:0];
    rght_nxt = t_r[SPD_W-1:0];
  end

  assign unused_bits = ^{t_err[31:ERR_SAT_W], t_p[31:SUM_W], t_int[31:INTEG_W], t_i[31:SUM_W],
                         t_d[31:SUM_W], t_sum[31:SUM_W], t_l[31:SPD_W], t_r[31:SPD_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      integ    <= '0;
      terms    <= '0;
      s1_vld   <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
    end else begin
      s1_vld  <= accept;
      out_vld <= s1_vld;
      // A stopped robot drops all accumulated state, even if a sample arrives on the same edge.
      if (!moving) begin
        integ <= '0;
        terms <= '0;
      end else if (err_vld) begin
        integ <= integ_nxt;
        terms <= terms_nxt;
      end
      lft_spd  <= moving ? lft_nxt  : '0;
      rght_spd <= moving ? rght_nxt : '0;
    end
  end

endmodule

// File: tb/tb_pid_gen.sv
// Bench for pid_gen: directed cases plus random traffic against an integer reference model.
module tb_pid_gen;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               moving = 1'b0;
  logic               err_vld = 1'b0;
  logic signed [11:0] error = '0;
  logic [9:0]         frwrd = '0;
  logic [4:0]         kp = '0;
  logic [4:0]         kd = '0;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               out_vld;

  int total = 0;
  int bad   = 0;

  int m_integ, m_p, m_i, m_d, m_lft, m_rght, m_vld, m_s1;
  int m_hist[$];

  pid_gen dut (
    .clk      (clk),
    .rst      (rst),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .kp       (kp),
    .kd       (kd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .out_vld  (out_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear_state();
    m_integ = 0; m_p = 0; m_i = 0; m_d = 0;
    m_hist = {};
    for (int i = 0; i < DEPTH; i++) m_hist.push_back(0);
  endtask

  // Behaviour of one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    int es, pid, old;
    if (rst) begin
      model_clear_state();
      m_lft = 0; m_rght = 0; m_vld = 0; m_s1 = 0;
      return;
    end
    if (moving) begin
      pid    = (m_p + m_i + m_d) >>> 3;
      m_lft  = sat(int'(frwrd) + pid, 11);
      m_rght = sat(int'(frwrd) - pid, 11);
    end else begin
      m_lft = 0; m_rght = 0;
    end
    m_vld = m_s1;
    m_s1  = (err_vld && moving) ? 1 : 0;
    if (!moving) begin
      model_clear_state();
    end else if (err_vld) begin
      es      = sat(int'(error), 10);
      m_p     = es * int'(kp);
      m_integ = sat(m_integ + es, 18);
      m_i     = m_integ >>> 6;
      old     = m_hist[DEPTH-1];
`ifdef PID_DTERM_EN
      m_d     = sat(es - old, 8) * int'(kd);
`else
      m_d     = 0;
`endif
      m_hist.push_front(es);
      void'(m_hist.pop_back());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("lft_model", int'(lft_spd), m_lft);
    chk("rght_model", int'(rght_spd), m_rght);
    chk("vld_model", int'(out_vld), m_vld);
  endtask

  task automatic do_reset();
    rst = 1'b1; err_vld = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a live sample on the inputs.
    rst = 1'b1; moving = 1'b1; err_vld = 1'b1; error = 12'sh100; kp = 5'd2; frwrd = 10'h100;
    repeat (2) begin
      step();
      chk("rst_lft", int'(lft_spd), 0);
      chk("rst_rght", int'(rght_spd), 0);
      chk("rst_vld", int'(out_vld), 0);
    end

    // Proportional path with a single pulse.
    do_reset();
    moving = 1'b1; kp = 5'd2; kd = 5'd0; frwrd = 10'h100; error = 12'sh100; err_vld = 1'b1;
    step();
    chk("p_vld_early", int'(out_vld), 0);
    err_vld = 1'b0;
    step();
    chk("p_lft", int'(lft_spd), 'h140);
    chk("p_rght", int'(rght_spd), 'h0C0);
    chk("p_vld", int'(out_vld), 1);
    step();
    chk("p_vld_drop", int'(out_vld), 0);

    // Output saturation at both rails.
    do_reset();
    kp = 5'd31; error = 12'sh7FF; err_vld = 1'b1;
    step();
    err_vld = 1'b0;
    step();
    chk("sat_lft", int'(lft_spd), 1023);
    chk("sat_rght", int'(rght_spd), -1024);

    // Integrator clamps rather than wrapping.
    do_reset();
    kp = 5'd0; kd = 5'd0; error = 12'sd511; err_vld = 1'b1;
    repeat (300) step();
    chk("clamp_vld_cont", int'(out_vld), 1);
    err_vld = 1'b0;
    step();
    chk("clamp_lft", int'(lft_spd), 'h1FF);
    chk("clamp_rght", int'(rght_spd), 'h001);

    // Dropping moving clears state even with a sample present.
    moving = 1'b0; err_vld = 1'b1;
    step();
    chk("stop_lft", int'(lft_spd), 0);
    chk("stop_rght", int'(rght_spd), 0);
    chk("stop_vld", int'(out_vld), 0);
    moving = 1'b1; error = 12'sd0;
    step();
    err_vld = 1'b0;
    step();
    chk("restart_lft", int'(lft_spd), 'h100);
    chk("restart_rght", int'(rght_spd), 'h100);

    // Derivative over the sample history.
    do_reset();
    kp = 5'd0; kd = 5'd4; frwrd = 10'h100; err_vld = 1'b1;
    error = 12'sd0;   step();
    error = 12'sd0;   step();
    error = 12'sd100; step();
    err_vld = 1'b0;
    step();
`ifdef PID_DTERM_EN
    chk("d_lft", int'(lft_spd), 'h132);
    chk("d_rght", int'(rght_spd), 'h0CE);
`else
    chk("d_lft", int'(lft_spd), 'h100);
    chk("d_rght", int'(rght_spd), 'h100);
`endif

    // A frwrd change alone moves the speeds one edge later without a strobe.
    frwrd = 10'h080;
    step();
    chk("frwrd_only_vld", int'(out_vld), 0);
    chk("frwrd_only_lft", int'(lft_spd), m_lft);

    // Random traffic, including mid-stream resets and stops.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      moving  = ($urandom_range(0, 19) != 0);
      err_vld = ($urandom_range(0, 9) < 7);
      error   = 12'($urandom);
      frwrd   = 10'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        kp = 5'($urandom);
        kd = 5'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
